jtframe_vidsel: RTL and testbench
=================================

JTFRAME_VIDSEL -- requirements
Module: jtframe_vidsel

Interface
REQ-001 Parameters (name, default, meaning):
- NSRC, 2: number of video sources (2..4).
- COLORW, 4: per-source colour-component width (4..8).
- MUTE_FRAMES, 1: frames of black after a switch (0..15).
REQ-002 Ports (name, direction, width, meaning):
- clk_sys, in, 1: the block's only clock.
- rst_n, in, 1: asynchronous, active-low reset.
- sel, in, 2: requested source index.
- src_r / src_g / src_b, in, NSRC*COLORW each: packed colour components; source k occupies bits [k*COLORW +: COLORW].
- src_hs, src_vs, src_de, src_cen, in, NSRC each: per-source sync, data-enable and pixel clock-enable.
- vid_r / vid_g / vid_b, out, 8 each: selected video.
- vid_hs, vid_vs, vid_de, vid_cen, out, 1 each: selected sync, enable and clock-enable.
- active_sel, out, 2: source currently driving the outputs.
- busy, out, 1: high while a switch is pending or the output is muted.
REQ-003 Clock and reset are fixed: one clock, clk_sys; reset rst_n is asynchronous and active-low.

Function
REQ-004 All outputs shall be registered on clk_sys, one cycle after the selected source's inputs.
REQ-005 Colour expansion shall be vid_x = ({c,c} >> (2*COLORW-8))[7:0], where c is the source's COLORW-bit component. This is bit replication, so all-ones maps to 8'hFF.
REQ-006 The FSM shall have three states: LOCKED, WAIT_VS and MUTE.
REQ-007 LOCKED: outputs follow source active_sel. When sel != active_sel and sel < NSRC, latch target = sel and go to WAIT_VS.
REQ-008 WAIT_VS: outputs keep following active_sel. On a rising edge of src_vs[target] (edge detected every clk_sys cycle, independent of cen):
- set active_sel = target and clear the frame counter;
- go to MUTE if MUTE_FRAMES > 0, otherwise to LOCKED.
REQ-009 MUTE: sync, de and cen shall follow the new active_sel, and vid_r/g/b shall be 0. Each rising edge of src_vs[active_sel] increments the counter. When the counter reaches MUTE_FRAMES, go to LOCKED; colour resumes on the next cycle.
REQ-010 If sel changes in WAIT_VS to another valid value != active_sel, target shall be reloaded and the wait restarted; no switch shall occur on the old target.
REQ-011 If sel returns to active_sel in WAIT_VS, the pending switch shall be cancelled and the FSM shall go to LOCKED.
REQ-012 If sel changes in MUTE to a valid value != active_sel, the FSM shall go to WAIT_VS with the new target, and colour shall stay muted until the new switch completes.
REQ-013 sel >= NSRC shall be ignored in every state.
REQ-014 A vs edge and a sel change in the same cycle: the vs edge acts on the target latched before that cycle; the new sel is evaluated on the next cycle.
REQ-015 busy shall be high exactly when the state is not LOCKED.
REQ-016 Counter width shall be 4 bits; it never wraps, because its compare stops it at MUTE_FRAMES.

Reset
REQ-017 While rst_n is low, the following shall hold:
- state = LOCKED, active_sel = 0, target = 0, counter = 0;
- vs edge-detect registers = 0;
- all vid_* outputs = 0, busy = 0.
REQ-018 Reset asserted mid-switch shall abandon the switch. After release, source 0 drives the outputs from the first clk_sys edge, with no mute period.

Structure
REQ-019 The FSM state enumeration and the expansion function shall live in the shared jtframe package, for reuse by other video blocks.
REQ-020 One sub-module shall be used: jtframe_vidsel_exp, a combinational COLORW-to-8 expander instantiated once per component.
REQ-021 Source selection shall be an indexed part-select on the packed buses; no per-source registers other than the vs edge detectors.

Verification
REQ-022 COLORW=4, source 0 with r=4'hA -> vid_r=8'hAA one clk_sys after the input; COLORW=5 with r=5'h1F -> 8'hFF.
REQ-023 MUTE_FRAMES=1; sel 0->1 mid-frame -> busy=1 and source 0 stays visible until vs1 rises; then active_sel=1 and colour=0 for exactly one src1 frame; colour resumes on the cycle after the second vs1 rise; busy=0.
REQ-024 sel 0->1, then ->2 before vs1 rises (NSRC=3) -> no switch at vs1; switch occurs at vs2 rise and active_sel=2.
REQ-025 sel 0->1->0 before vs1 -> busy falls the cycle after sel returns; active_sel stays 0 and colour is never muted.
REQ-026 sel=3 with NSRC=2 -> state stays LOCKED, busy=0, outputs unchanged.
REQ-027 rst_n low during MUTE -> all outputs 0 asynchronously; after release active_sel=0, busy=0, source 0 colour visible immediately.

Source files
------------

// File: rtl/jtframe_pkg.sv
// Shared jtframe video types: source-switch FSM states and colour expansion.
// Pure declarations, no latency; no flow control.
package jtframe_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    WAIT_VS = 2'd1,
    MUTE    = 2'd2
  } vidsel_state_t;

  // Replicates a w-bit component into 8 bits; w must be 4..8.
  function automatic logic [7:0] vidsel_expand(input logic [7:0] c, input int unsigned w);
    logic [15:0] cm;
    logic [15:0] cc;
    logic [15:0] sh;
    cm = {8'd0, c} & ((16'd1 << w) - 16'd1);
    cc = (cm << w) | cm;
    sh = cc >> (2 * w - 8);
    return sh[7:0];
  endfunction

endpackage

// File: rtl/jtframe_vidsel_exp.sv
// Combinational COLORW-to-8 colour expander by bit replication.
// Zero latency; no flow control.
module jtframe_vidsel_exp
  import jtframe_pkg::*;
#(
  parameter int COLORW = 4
) (
  input  logic [COLORW-1:0] c,
  output logic [7:0]        x
);

  assign x = vidsel_expand(8'(c), unsigned'(COLORW));

endmodule

// File: rtl/jtframe_vidsel.sv
// Video source selector: switches on the target's vs rise, then mutes colour for MUTE_FRAMES frames.
// Outputs registered one clk_sys after the selected source; no backpressure, busy flags a pending switch.
module jtframe_vidsel
  import jtframe_pkg::*;
#(
  parameter int NSRC        = 2,
  parameter int COLORW      = 4,
  parameter int MUTE_FRAMES = 1
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic [1:0]             sel,
  input  logic [NSRC*COLORW-1:0] src_r,
  input  logic [NSRC*COLORW-1:0] src_g,
  input  logic [NSRC*COLORW-1:0] src_b,
  input  logic [NSRC-1:0]        src_hs,
  input  logic [NSRC-1:0]        src_vs,
  input  logic [NSRC-1:0]        src_de,
  input  logic [NSRC-1:0]        src_cen,
  output logic [7:0]             vid_r,
  output logic [7:0]             vid_g,
  output logic [7:0]             vid_b,
  output logic                   vid_hs,
  output logic                   vid_vs,
  output logic                   vid_de,
  output logic                   vid_cen,
  output logic [1:0]             active_sel,
  output logic                   busy
);

  localparam logic [2:0] NSRC_L = 3'(NSRC);
  localparam logic [3:0] MUTE_L = 4'(MUTE_FRAMES);

  vidsel_state_t state, state_nx;
  logic [1:0]      target, target_nx, active_nx;
  logic [3:0]      cnt, cnt_nx;
  logic            hold, hold_nx;
  logic            mute;
  logic            sel_ok;
  logic [NSRC-1:0] vs_d;
  logic [3:0]      vs_rise4, hs4, vs4, de4, cen4;
  logic [7:0]      exp_r, exp_g, exp_b;

  // Widen per-source bits to 4 so a 2-bit index is always in range.
  assign vs_rise4 = 4'(src_vs & ~vs_d);
  assign hs4      = 4'(src_hs);
  assign vs4      = 4'(src_vs);
  assign de4      = 4'(src_de);
  assign cen4     = 4'(src_cen);
  assign sel_ok   = {1'b0, sel} < NSRC_L;

  jtframe_vidsel_exp #(.COLORW(COLORW)) u_exp_r (.c(src_r[int'(active_sel)*COLORW +: COLORW]), .x(exp_r));
  jtframe_vidsel_exp #(.COLORW(COLORW)) u_exp_g (.c(src_g[int'(active_sel)*COLORW +: COLORW]), .x(exp_g));
  jtframe_vidsel_exp #(.COLORW(COLORW)) u_exp_b (.c(src_b[int'(active_sel)*COLORW +: COLORW]), .x(exp_b));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      active_sel <= 2'd0;
      target     <= 2'd0;
      cnt        <= 4'd0;
      hold       <= 1'b0;
      vs_d       <= '0;
    end else begin
      state      <= state_nx;
      active_sel <= active_nx;
      target     <= target_nx;
      cnt        <= cnt_nx;
      hold       <= hold_nx;
      vs_d       <= src_vs;
    end
  end

  // A vs edge always wins over a same-cycle sel change; sel is re-examined next cycle.
  always_comb begin
    state_nx  = state;
    active_nx = active_sel;
    target_nx = target;
    cnt_nx    = cnt;
    hold_nx   = hold;
    case (state)
      LOCKED: begin
        if (sel_ok && sel != active_sel) begin
          target_nx = sel;
          state_nx  = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vs_rise4[target]) begin
          active_nx = target;
          cnt_nx    = 4'd0;
          hold_nx   = 1'b0;
          state_nx  = (MUTE_FRAMES > 0) ? MUTE : LOCKED;
        end else if (sel_ok) begin
          if (sel == active_sel) begin
            hold_nx  = 1'b0;
            state_nx = LOCKED;
          end else begin
            target_nx = sel;
          end
        end
      end
      MUTE: begin
        if (vs_rise4[active_sel]) begin
          cnt_nx = cnt + 4'd1;
          if (cnt_nx == MUTE_L) state_nx = LOCKED;
        end else if (sel_ok && sel != active_sel) begin
          target_nx = sel;
          hold_nx   = 1'b1;
          state_nx  = WAIT_VS;
        end
      end
      default: state_nx = LOCKED;
    endcase
  end

  // hold keeps colour dark when a new switch is requested while still muted.
  always_comb begin
    mute = (state == MUTE) || (state == WAIT_VS && hold);
    busy = (state != LOCKED);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      vid_r   <= 8'd0;
      vid_g   <= 8'd0;
      vid_b   <= 8'd0;
      vid_hs  <= 1'b0;
      vid_vs  <= 1'b0;
      vid_de  <= 1'b0;
      vid_cen <= 1'b0;
    end else begin
      vid_r   <= mute ? 8'd0 : exp_r;
      vid_g   <= mute ? 8'd0 : exp_g;
      vid_b   <= mute ? 8'd0 : exp_b;
      vid_hs  <= hs4[active_sel];
      vid_vs  <= vs4[active_sel];
      vid_de  <= de4[active_sel];
      vid_cen <= cen4[active_sel];
    end
  end

endmodule

// File: tb/tb_jtframe_vidsel.sv
// Bench for jtframe_vidsel: expander vector table, directed switch sequences, randomized run vs a reference model.
module tb_jtframe_vidsel;

  localparam int NS = 3;
  localparam int CW = 5;
  localparam int MF = 1;

  logic clk_sys = 1'b0;
  logic rst_n;
  logic [1:0]       sel;
  logic [NS*CW-1:0] src_r, src_g, src_b;
  logic [NS-1:0]    src_hs, src_vs, src_de, src_cen;
  logic [7:0]       vid_r, vid_g, vid_b;
  logic             vid_hs, vid_vs, vid_de, vid_cen;
  logic [1:0]       active_sel;
  logic             busy;

  logic [3:0] c4;  logic [4:0] c5;  logic [5:0] c6;  logic [6:0] c7;  logic [7:0] c8;
  logic [7:0] x4, x5, x6, x7, x8;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_active, m_pend, m_cnt;
  bit m_mute, m_hold;
  logic [NS-1:0] m_vsp;

  jtframe_vidsel #(.NSRC(NS), .COLORW(CW), .MUTE_FRAMES(MF)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .sel(sel),
    .src_r(src_r), .src_g(src_g), .src_b(src_b),
    .src_hs(src_hs), .src_vs(src_vs), .src_de(src_de), .src_cen(src_cen),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_cen(vid_cen),
    .active_sel(active_sel), .busy(busy)
  );

  jtframe_vidsel_exp #(.COLORW(4)) u_x4 (.c(c4), .x(x4));
  jtframe_vidsel_exp #(.COLORW(5)) u_x5 (.c(c5), .x(x5));
  jtframe_vidsel_exp #(.COLORW(6)) u_x6 (.c(c6), .x(x6));
  jtframe_vidsel_exp #(.COLORW(7)) u_x7 (.c(c7), .x(x7));
  jtframe_vidsel_exp #(.COLORW(8)) u_x8 (.c(c8), .x(x8));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // replication written as a multiply: c * (2^w + 1) is {c,c}
  function automatic int mexp(input int c, input int w);
    return ((c * ((1 << w) + 1)) >> (2 * w - 8)) & 255;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pend = -1; m_cnt = 0; m_mute = 0; m_hold = 0; m_vsp = '0;
  endtask

  task automatic step();
    int s, er, eg, eb, esync;
    bit muted, sel_ok;
    logic [NS-1:0] rise;
    @(posedge clk_sys);
    s = m_active;
    muted = m_mute || (m_pend >= 0 && m_hold);
    er = muted ? 0 : mexp(int'(src_r[s*CW +: CW]), CW);
    eg = muted ? 0 : mexp(int'(src_g[s*CW +: CW]), CW);
    eb = muted ? 0 : mexp(int'(src_b[s*CW +: CW]), CW);
    esync = {src_hs[s], src_vs[s], src_de[s], src_cen[s]};
    rise = src_vs & ~m_vsp;
    sel_ok = int'(sel) < NS;
    if (m_pend >= 0) begin
      if (rise[m_pend]) begin
        m_active = m_pend; m_pend = -1; m_hold = 0; m_cnt = 0; m_mute = (MF > 0);
      end else if (sel_ok) begin
        if (int'(sel) == m_active) begin m_pend = -1; m_hold = 0; end
        else m_pend = int'(sel);
      end
    end else if (m_mute) begin
      if (rise[m_active]) begin
        m_cnt++;
        if (m_cnt == MF) m_mute = 0;
      end else if (sel_ok && int'(sel) != m_active) begin
        m_pend = int'(sel); m_hold = 1; m_mute = 0;
      end
    end else if (sel_ok && int'(sel) != m_active) begin
      m_pend = int'(sel);
    end
    m_vsp = src_vs;
    #1;
    chk("vid_r", int'(vid_r), er);
    chk("vid_g", int'(vid_g), eg);
    chk("vid_b", int'(vid_b), eb);
    chk("sync", int'({vid_hs, vid_vs, vid_de, vid_cen}), esync);
    chk("active_sel", int'(active_sel), m_active);
    chk("busy", int'(busy), int'(m_pend >= 0 || m_mute));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rgb"}, int'({vid_r, vid_g, vid_b}), 0);
    chk({tag, "_sync"}, int'({vid_hs, vid_vs, vid_de, vid_cen}), 0);
    chk({tag, "_active"}, int'(active_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // asserted away from the clock edge to exercise the asynchronous path
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    chk_zero("rst_hold");
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  typedef struct { int w; int c; int exp; } xvec_t;
  xvec_t xv[12];

  initial begin
    xv[0]  = '{4, 'hA,  'hAA};  xv[1]  = '{4, 'hF,  'hFF};  xv[2]  = '{4, 'h0,  'h00};
    xv[3]  = '{5, 'h1F, 'hFF};  xv[4]  = '{5, 'h10, 'h84};  xv[5]  = '{5, 'h01, 'h08};
    xv[6]  = '{6, 'h3F, 'hFF};  xv[7]  = '{6, 'h20, 'h82};  xv[8]  = '{7, 'h7F, 'hFF};
    xv[9]  = '{7, 'h40, 'h81};  xv[10] = '{8, 'h5A, 'h5A};  xv[11] = '{8, 'hFF, 'hFF};

    rst_n = 1'b0; sel = 2'd0;
    src_r = '0; src_g = '0; src_b = '0;
    src_hs = '0; src_vs = '0; src_de = '0; src_cen = '0;
    c4 = '0; c5 = '0; c6 = '0; c7 = '0; c8 = '0;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      int got;
      case (xv[i].w)
        4: c4 = 4'(xv[i].c);
        5: c5 = 5'(xv[i].c);
        6: c6 = 6'(xv[i].c);
        7: c7 = 7'(xv[i].c);
        default: c8 = 8'(xv[i].c);
      endcase
      #1;
      case (xv[i].w)
        4: got = int'(x4);
        5: got = int'(x5);
        6: got = int'(x6);
        7: got = int'(x7);
        default: got = int'(x8);
      endcase
      chk($sformatf("expand_w%0d_%0h", xv[i].w, xv[i].c), got, xv[i].exp);
    end

    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // mute-period sequence with fixed colours per source
    src_r = {5'h01, 5'h10, 5'h1F};
    src_g = {5'h02, 5'h03, 5'h04};
    src_b = {5'h05, 5'h06, 5'h07};
    src_hs = 3'b010; src_de = 3'b110; src_cen = 3'b101;
    step(); step();
    chk("src0_r_ff", int'(vid_r), 'hFF);
    sel = 2'd1; step();
    chk("pend_busy", int'(busy), 1);
    chk("pend_active", int'(active_sel), 0);
    step();
    chk("pend_visible", int'(vid_r), 'hFF);
    src_vs = 3'b010; step();
    chk("switch_active", int'(active_sel), 1);
    step();
    chk("mute_r", int'(vid_r), 0);
    chk("mute_hs", int'(vid_hs), 1);
    src_vs = 3'b000; step(); step();
    chk("mute_hold_r", int'(vid_r), 0);
    chk("mute_busy", int'(busy), 1);
    src_vs = 3'b010; step();
    chk("unmute_busy", int'(busy), 0);
    chk("unmute_still0", int'(vid_r), 0);
    step();
    chk("resume_r", int'(vid_r), 'h84);

    // cancel by returning to the active source
    src_vs = 3'b000; step();
    sel = 2'd0; step();
    chk("cancel_busy1", int'(busy), 1);
    sel = 2'd1; step();
    chk("cancel_busy0", int'(busy), 0);
    chk("cancel_active", int'(active_sel), 1);
    chk("cancel_nomute", int'(vid_r), 'h84);

    // retarget: no switch on the abandoned target's vs
    sel = 2'd0; step();
    sel = 2'd2; step();
    src_vs = 3'b001; step();
    chk("retarget_noswitch", int'(active_sel), 1);
    chk("retarget_busy", int'(busy), 1);
    src_vs = 3'b101; step();
    chk("retarget_active2", int'(active_sel), 2);
    src_vs = 3'b000; step();
    src_vs = 3'b100; step();
    chk("retarget_done", int'(busy), 0);

    // out-of-range select is ignored
    sel = 2'd3; step(); step(); step();
    chk("sel3_busy", int'(busy), 0);
    chk("sel3_active", int'(active_sel), 2);
    chk("sel3_r", int'(vid_r), 'h08);

    // reset during mute abandons the switch
    sel = 2'd0; src_vs = 3'b000; step();
    src_vs = 3'b001; step();
    step();
    chk("pre_rst_mute", int'(vid_r), 0);
    do_reset();
    step();
    chk("post_rst_active", int'(active_sel), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_r", int'(vid_r), 'hFF);

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      src_r = 15'($urandom); src_g = 15'($urandom); src_b = 15'($urandom);
      src_hs = 3'($urandom); src_de = 3'($urandom); src_cen = 3'($urandom);
      for (int k = 0; k < NS; k++)
        if ($urandom_range(0, 11) == 0) src_vs[k] = ~src_vs[k];
      if ($urandom_range(0, 24) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
